// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller for the OTTER pipeline. Each cycle it
//               decides whether the PC register is written and with what
//               value: boot vector, sequential +4, branch/jump redirect,
//               mret return or interrupt vector. Runs the two-cycle
//               interrupt entry (save mepc, then jump to mtvec), issues the
//               pipeline flush and flags instruction-memory timeouts.
// Ports       : pc_clk, pc_rst (async, active-high)
//               pc_cur, stall, imem_ready          - fetch-side status
//               redirect, redirect_tgt, mret, mepc  - EX-stage / CSR inputs
//               intr_req, mie, mtvec                - interrupt inputs
//               pc_write, pc_din                    - PC register control
//               flush, mepc_we, mepc_wdata          - pipeline / CSR control
//               intr_ack, mie_clr, fetch_err        - status outputs
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  wire logic        pc_clk,
    input  wire logic        pc_rst,
    input  wire logic [31:0] pc_cur,
    input  wire logic        stall,
    input  wire logic        imem_ready,
    input  wire logic        redirect,
    input  wire logic [31:0] redirect_tgt,
    input  wire logic        mret,
    input  wire logic [31:0] mepc,
    input  wire logic        intr_req,
    input  wire logic        mie,
    input  wire logic [31:0] mtvec,
    output logic             pc_write,
    output logic [31:0]      pc_din,
    output logic             flush,
    output logic             mepc_we,
    output logic [31:0]      mepc_wdata,
    output logic             intr_ack,
    output logic             mie_clr,
    output logic             fetch_err
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [31:0] C_RESET_VEC = {RESET_VEC[31:2], 2'b00};
    localparam logic [7:0]  C_TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [7:0]  w_cnt_inc;
    logic        r_fetch_err;

    logic [31:0] w_pc_aligned;
    logic [31:0] w_pc_seq;
    logic [31:0] w_redir_pc;
    logic [31:0] w_mret_pc;
    logic [31:0] w_trap_pc;
    logic        w_unused_bits;

    // All redirect targets are forced word-aligned; the 32-bit add wraps
    // naturally from 32'hFFFF_FFFC to 32'h0000_0000.
    assign w_pc_aligned  = {pc_cur[31:2], 2'b00};
    assign w_pc_seq      = w_pc_aligned + 32'd4;
    assign w_redir_pc    = {redirect_tgt[31:2], 2'b00};
    assign w_mret_pc     = {mepc[31:2], 2'b00};
    assign w_trap_pc     = {mtvec[31:2], 2'b00};
    assign w_cnt_inc     = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_unused_bits = ^{redirect_tgt[1:0], mepc[1:0], mtvec[1:0]};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        pc_write     = 1'b0;
        pc_din       = w_pc_aligned;
        flush        = 1'b0;
        mepc_we      = 1'b0;
        mepc_wdata   = 32'h0000_0000;
        intr_ack     = 1'b0;
        mie_clr      = 1'b0;

        case (r_state)
            ST_BOOT: begin
                pc_write     = 1'b1;
                pc_din       = C_RESET_VEC;
                flush        = 1'b1;
                w_cnt_next   = 8'd0;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_write = 1'b1;
                    pc_din   = w_redir_pc;
                    flush    = 1'b1;
                end else if (mret) begin
                    pc_write = 1'b1;
                    pc_din   = w_mret_pc;
                    flush    = 1'b1;
                end else if (intr_req && mie && !stall) begin
                    // First half of interrupt entry: save the PC, hold it.
                    mepc_we      = 1'b1;
                    mepc_wdata   = pc_cur;
                    flush        = 1'b1;
                    w_state_next = ST_TRAP;
                end else if (stall) begin
                    pc_din = w_pc_aligned;
                end else if (!imem_ready) begin
                    w_cnt_next   = 8'd1;
                    w_state_next = ST_WAIT;
                end else begin
                    pc_write = 1'b1;
                    pc_din   = w_pc_seq;
                end
            end
            ST_TRAP: begin
                // A redirect arriving here wins; the still-pending interrupt
                // is simply re-evaluated once back in RUN.
                if (redirect) begin
                    pc_write = 1'b1;
                    pc_din   = w_redir_pc;
                    flush    = 1'b1;
                end else begin
                    pc_write = 1'b1;
                    pc_din   = w_trap_pc;
                    intr_ack = 1'b1;
                    mie_clr  = 1'b1;
                    flush    = 1'b1;
                end
                w_state_next = ST_RUN;
            end
            ST_WAIT: begin
                w_cnt_next = w_cnt_inc;
                if (redirect) begin
                    pc_write     = 1'b1;
                    pc_din       = w_redir_pc;
                    flush        = 1'b1;
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_RUN;
                end else if (imem_ready && !stall) begin
                    pc_write     = 1'b1;
                    pc_din       = w_pc_seq;
                    w_cnt_next   = 8'd0;
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_cnt_next   = 8'd0;
                w_state_next = ST_BOOT;
            end
        endcase

        // Outputs return to their reset values the moment reset asserts,
        // not at the next edge, so a trap in flight never acknowledges.
        if (pc_rst) begin
            pc_write   = 1'b0;
            pc_din     = C_RESET_VEC;
            flush      = 1'b0;
            mepc_we    = 1'b0;
            mepc_wdata = 32'h0000_0000;
            intr_ack   = 1'b0;
            mie_clr    = 1'b0;
        end
    end

    always_ff @(posedge pc_clk or posedge pc_rst) begin
        if (pc_rst) begin
            r_state     <= ST_BOOT;
            r_cnt       <= 8'd0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Sticky: set on the edge where the count reaches the limit.
            if (w_cnt_next >= C_TIMEOUT)
                r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. Stimulus drives the
//               inputs just after each rising edge and queues the expected
//               outputs; a monitor compares on each falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic        stall;
    logic        imem_ready;
    logic        redirect;
    logic [31:0] redirect_tgt;
    logic        mret;
    logic [31:0] mepc;
    logic        intr_req;
    logic        mie;
    logic [31:0] mtvec;
    logic        pc_write;
    logic [31:0] pc_din;
    logic        flush;
    logic        mepc_we;
    logic [31:0] mepc_wdata;
    logic        intr_ack;
    logic        mie_clr;
    logic        fetch_err;

    int tests_run = 0;
    int tests_failed = 0;

    pc_sequencer #(
        .RESET_VEC  (32'h0000_0000),
        .MEM_TIMEOUT(16)
    ) dut (
        .pc_clk      (clk),
        .pc_rst      (rst),
        .pc_cur      (pc_cur),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .redirect    (redirect),
        .redirect_tgt(redirect_tgt),
        .mret        (mret),
        .mepc        (mepc),
        .intr_req    (intr_req),
        .mie         (mie),
        .mtvec       (mtvec),
        .pc_write    (pc_write),
        .pc_din      (pc_din),
        .flush       (flush),
        .mepc_we     (mepc_we),
        .mepc_wdata  (mepc_wdata),
        .intr_ack    (intr_ack),
        .mie_clr     (mie_clr),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        pw;
        logic [31:0] din;
        logic        chk_din;
        logic        fl;
        logic        mwe;
        logic [31:0] mwd;
        logic        ack;
        logic        clr;
        logic        ferr;
    } exp_t;

    exp_t exp_q[$];

    task automatic expect_out(input string n, input logic pw, input logic [31:0] din,
                              input logic chk_din, input logic fl, input logic mwe,
                              input logic [31:0] mwd, input logic ack, input logic clr,
                              input logic ferr);
        exp_t e;
        e.name = n; e.pw = pw; e.din = din; e.chk_din = chk_din; e.fl = fl;
        e.mwe = mwe; e.mwd = mwd; e.ack = ack; e.clr = clr; e.ferr = ferr;
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        stall = 1'b0; imem_ready = 1'b1; redirect = 1'b0; mret = 1'b0;
        intr_req = 1'b0; mie = 1'b0;
    endtask

    // Monitor: one queued expectation is compared per falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic bad;
            e = exp_q.pop_front();
            bad = (pc_write !== e.pw) || (e.chk_din && (pc_din !== e.din)) ||
                  (flush !== e.fl) || (mepc_we !== e.mwe) ||
                  (e.mwe && (mepc_wdata !== e.mwd)) || (intr_ack !== e.ack) ||
                  (mie_clr !== e.clr) || (fetch_err !== e.ferr) || (pc_din[1:0] !== 2'b00);
            tests_run++;
            if (bad) begin
                tests_failed++;
                $display("FAIL %s: got pw=%b din=%h fl=%b mwe=%b mwd=%h ack=%b clr=%b ferr=%b; want pw=%b din=%h(chk=%b) fl=%b mwe=%b mwd=%h ack=%b clr=%b ferr=%b",
                         e.name, pc_write, pc_din, flush, mepc_we, mepc_wdata, intr_ack,
                         mie_clr, fetch_err, e.pw, e.din, e.chk_din, e.fl, e.mwe, e.mwd,
                         e.ack, e.clr, e.ferr);
            end
        end
    end

    initial begin
        rst = 1'b1; pc_cur = 32'h0; redirect_tgt = 32'h0; mepc = 32'h0; mtvec = 32'h0;
        idle();
        tick();

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            expect_out("reset", 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
            tick();
        end
        rst = 1'b0;
        expect_out("boot", 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        expect_out("first_seq", 1, 32'h4, 1, 0, 0, 0, 0, 0, 0);
        tick();

        // Sequential wrap
        pc_cur = 32'hFFFF_FFFC;
        expect_out("wrap", 1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        tick();

        // Redirect overrides stall, target aligned
        stall = 1'b1; redirect = 1'b1; redirect_tgt = 32'h0000_0123; pc_cur = 32'h10;
        expect_out("redir_vs_stall", 1, 32'h120, 1, 1, 0, 0, 0, 0, 0);
        tick();
        redirect = 1'b0;
        expect_out("stall", 0, 32'h10, 1, 0, 0, 0, 0, 0, 0);
        tick();
        idle();

        // mret return, aligned
        mret = 1'b1; mepc = 32'h0000_0207;
        expect_out("mret", 1, 32'h204, 1, 1, 0, 0, 0, 0, 0);
        tick();
        idle();

        // Interrupt ignored with mie=0, and under stall
        pc_cur = 32'h20; intr_req = 1'b1; mie = 1'b0;
        expect_out("intr_masked", 1, 32'h24, 1, 0, 0, 0, 0, 0, 0);
        tick();
        mie = 1'b1; stall = 1'b1;
        expect_out("intr_stalled", 0, 32'h20, 1, 0, 0, 0, 0, 0, 0);
        tick();
        stall = 1'b0;

        // Interrupt entry
        pc_cur = 32'h40; mtvec = 32'h100;
        expect_out("intr_save", 0, 32'h0, 0, 1, 1, 32'h40, 0, 0, 0);
        tick();
        expect_out("intr_vector", 1, 32'h100, 1, 1, 0, 0, 1, 1, 0);
        tick();
        idle(); pc_cur = 32'h100;
        expect_out("after_intr", 1, 32'h104, 1, 0, 0, 0, 0, 0, 0);
        tick();

        // Interrupt aborted by redirect in TRAP, then taken later
        pc_cur = 32'h40; intr_req = 1'b1; mie = 1'b1;
        expect_out("abort_save", 0, 32'h0, 0, 1, 1, 32'h40, 0, 0, 0);
        tick();
        redirect = 1'b1; redirect_tgt = 32'h80;
        expect_out("abort_redir", 1, 32'h80, 1, 1, 0, 0, 0, 0, 0);
        tick();
        redirect = 1'b0; pc_cur = 32'h80;
        expect_out("retake_save", 0, 32'h0, 0, 1, 1, 32'h80, 0, 0, 0);
        tick();
        expect_out("retake_vector", 1, 32'h100, 1, 1, 0, 0, 1, 1, 0);
        tick();
        idle();

        // Fetch timeout: fetch_err visible from the 17th low cycle
        pc_cur = 32'h200;
        for (int i = 1; i <= 17; i++) begin
            imem_ready = 1'b0;
            expect_out("timeout", 0, 32'h0, 0, 0, 0, 0, 0, 0, (i >= 17));
            tick();
        end
        imem_ready = 1'b1;
        expect_out("wait_exit", 1, 32'h204, 1, 0, 0, 0, 0, 0, 1);
        tick();
        pc_cur = 32'h204;
        expect_out("err_sticky", 1, 32'h208, 1, 0, 0, 0, 0, 0, 1);
        tick();

        // WAIT: interrupts ignored, redirect leaves
        pc_cur = 32'h300; imem_ready = 1'b0;
        expect_out("enter_wait", 0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        intr_req = 1'b1; mie = 1'b1;
        expect_out("wait_no_intr", 0, 32'h0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        intr_req = 1'b0; mie = 1'b0; redirect = 1'b1; redirect_tgt = 32'h0000_0406;
        expect_out("wait_redir", 1, 32'h404, 1, 1, 0, 0, 0, 0, 1);
        tick();
        idle();

        // Async reset in the middle of TRAP
        pc_cur = 32'h40; intr_req = 1'b1; mie = 1'b1;
        expect_out("rst_trap_save", 0, 32'h0, 0, 1, 1, 32'h40, 0, 0, 1);
        tick();
        #2 rst = 1'b1;
        expect_out("rst_mid_trap", 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        expect_out("rst_hold", 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0; idle(); pc_cur = 32'h0;
        expect_out("reboot", 1, 32'h0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        expect_out("reboot_seq", 1, 32'h4, 1, 0, 0, 0, 0, 0, 0);
        tick();

        // Drain with a bounded wait
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-PC controller for the OTTER pipeline.
- Decides each cycle whether the program counter register is written, and with what value: boot vector, sequential +4, branch/jump redirect, mret return, or interrupt vector.
- Sequences the two-cycle interrupt entry (save mepc, then jump to mtvec).
- Issues the IF/ID flush and watches for instruction-memory timeouts.
- Sits between hazard unit / EX stage / CSR file and the program counter register.

Parameters:
- RESET_VEC, 32'h0000_0000, PC loaded on the boot cycle after reset.
- MEM_TIMEOUT, 16, consecutive imem_ready-low cycles before fetch_err sets (range 1..255).

Ports:
- pc_clk  in  1  clock; all state on rising edge.
- pc_rst  in  1  reset, asynchronous, active-high.
- pc_cur  in  32  current PC register value.
- stall  in  1  hazard-unit stall request.
- imem_ready  in  1  instruction memory has delivered the fetch at pc_cur.
- redirect  in  1  EX-stage taken branch / jal / jalr.
- redirect_tgt  in  32  target for redirect.
- mret  in  1  mret in EX.
- mepc  in  32  CSR mepc value.
- intr_req  in  1  level interrupt request.
- mie  in  1  global interrupt enable.
- mtvec  in  32  trap vector base.
- pc_write  out  1  write enable to PC register.
- pc_din  out  32  value to load into PC.
- flush  out  1  flush IF/ID and ID/EX.
- mepc_we  out  1  write mepc.
- mepc_wdata  out  32  value for mepc.
- intr_ack  out  1  interrupt taken (one-cycle pulse).
- mie_clr  out  1  clear mie (one-cycle pulse).
- fetch_err  out  1  sticky imem timeout flag.

Behaviour:
- Reset (async, while pc_rst=1):
  - state=BOOT, timeout counter=0.
  - pc_write=0, pc_din=RESET_VEC, all other outputs 0.
- State BOOT (first cycle after pc_rst falls):
  - pc_write=1, pc_din=RESET_VEC, flush=1.
  - Next state is RUN. All other inputs are ignored.
- State RUN. Priority is highest first, evaluated combinationally from current-cycle inputs:
  1. redirect: pc_write=1, pc_din={redirect_tgt[31:2],2'b00}, flush=1. Overrides stall and imem_ready=0.
  2. mret: pc_write=1, pc_din={mepc[31:2],2'b00}, flush=1.
  3. intr_req & mie & !stall: pc_write=0, mepc_we=1, mepc_wdata=pc_cur, flush=1. Next state TRAP.
  4. stall: pc_write=0, pc_din=pc_cur.
  5. !imem_ready: pc_write=0. Next state WAIT, counter=1.
  6. Otherwise: pc_write=1, pc_din=pc_cur+4, computed modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
- State TRAP (exactly one cycle):
  - If redirect=1: abort the trap. Perform redirect as in RUN; intr_ack=0, mie_clr=0. Next state RUN; the interrupt is re-evaluated there.
  - Else: pc_write=1, pc_din={mtvec[31:2],2'b00}, intr_ack=1, mie_clr=1, flush=1. Next state RUN.
- State WAIT:
  - pc_write=0 and the counter increments, saturating at 255.
  - redirect=1: handled as in RUN, counter cleared, next state RUN.
  - imem_ready=1 and !stall: pc_write=1, pc_din=pc_cur+4, counter cleared, next state RUN.
  - Interrupts are not taken in WAIT.
- fetch_err:
  - Sets in the cycle after the counter reaches MEM_TIMEOUT.
  - Cleared only by pc_rst.
  - Does not halt sequencing.
- General rules:
  - flush, intr_ack, mie_clr and mepc_we are single-cycle pulses.
  - pc_din is always word-aligned (bits [1:0]=0).
  - Reset asserted mid-TRAP or mid-WAIT: immediate return to reset outputs; no intr_ack is emitted.

Test Plan:
- Boot: hold pc_rst 3 cycles, release -> one cycle pc_write=1, pc_din=0, flush=1; next cycle pc_din=pc_cur+4=0x4.
- Wrap: pc_cur=0xFFFF_FFFC, all inputs idle, imem_ready=1 -> pc_din=0x0000_0000, pc_write=1.
- Redirect vs stall: stall=1, redirect=1, redirect_tgt=0x0000_0123 -> pc_write=1, pc_din=0x0000_0120, flush=1.
- Interrupt: pc_cur=0x40, intr_req=1, mie=1, mtvec=0x100 ->
  - cycle 1: mepc_we=1, mepc_wdata=0x40, pc_write=0.
  - cycle 2: pc_din=0x100, pc_write=1, intr_ack=1, mie_clr=1.
  - Repeat with redirect=1 (redirect_tgt=0x80) in cycle 2 -> pc_din=0x80, intr_ack=0; interrupt taken later.
- Timeout: imem_ready=0 for 17 cycles with MEM_TIMEOUT=16 -> pc_write=0 throughout, fetch_err=1 from cycle 17. imem_ready=1 -> PC advances, fetch_err stays 1 until pc_rst.
- Async reset mid-TRAP: assert pc_rst between clock edges in TRAP -> pc_write=0 and intr_ack=0 immediately; BOOT on release.
